online_burst_packer: RTL and testbench

Collects online-arithmetic result digit vectors (`Dout`, one per `variable_clk` beat) into `burst_index`-wide memory words and issues them as write transactions with address generation and back-pressure. It sits between the online operator output and the capture memory. Beat counting, partial-burst flush and a one-deep output holding register make every emitted word complete and aligned, which a free-running shifter cannot guarantee.

---
 rtl/online_burst_packer_pkg.sv | 18 +
 rtl/online_burst_packer_if.sv | 26 ++
 rtl/online_burst_packer_burst_out_reg.sv | 41 ++++
 rtl/online_burst_packer.sv | 90 +++++++++
 tb/tb_online_burst_packer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/online_burst_packer_pkg.sv
// rtl/online_burst_packer_pkg.sv - shared online-arithmetic constants, result width helper and packer FSM states
package online_pkg;

  localparam int DEFAULT_NO_OF_DIGITS = 8;
  localparam int DEFAULT_RADIX_BITS   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } pack_state_e;

  // One result carries a leading integer digit plus no_of_digits fraction digits.
  function automatic int calc_nb(input int digits, input int rbits);
    return (digits + 1) * rbits;
  endfunction

endpackage

// File: rtl/online_burst_packer_if.sv
// rtl/online_burst_packer_if.sv - result beat input and memory write port of the burst packer
interface online_burst_packer_if #(
  parameter int NB          = 27,
  parameter int BURST_INDEX = 8,
  parameter int ADDR_BITS   = 10
);
  logic [NB-1:0]             Dout;
  logic                      din_valid;
  logic                      din_ready;
  logic                      flush;
  logic [NB*BURST_INDEX-1:0] mem_in;
  logic                      mem_we;
  logic                      mem_ready;
  logic [ADDR_BITS-1:0]      mem_addr;
  logic [3:0]                beat_cnt;

  modport master (
    output Dout, din_valid, flush, mem_ready,
    input  din_ready, mem_in, mem_we, mem_addr, beat_cnt
  );

  modport slave (
    input  Dout, din_valid, flush, mem_ready,
    output din_ready, mem_in, mem_we, mem_addr, beat_cnt
  );
endinterface

// File: rtl/online_burst_packer_burst_out_reg.sv
// rtl/online_burst_packer_burst_out_reg.sv - one-entry write holding register with we/ready handshake and address counter
module burst_out_reg #(
  parameter int W         = 216,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [W-1:0]         i_data,
  input  logic                 i_ready,
  output logic                 o_we,
  output logic [W-1:0]         o_data,
  output logic [ADDR_BITS-1:0] o_addr
);
  logic                 r_we;
  logic [W-1:0]         r_data;
  logic [ADDR_BITS-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
    end else begin
      if (r_we && i_ready) begin
        r_addr <= r_addr + ADDR_BITS'(1);
      end
      // A load in the accepting cycle replaces the word with no bubble.
      if (i_load) begin
        r_we   <= 1'b1;
        r_data <= i_data;
      end else if (i_ready) begin
        r_we <= 1'b0;
      end
    end
  end

  assign o_we   = r_we;
  assign o_data = r_data;
  assign o_addr = r_addr;
endmodule

// File: rtl/online_burst_packer.sv
// rtl/online_burst_packer.sv - packs online result beats into aligned memory words with flush and back-pressure
module online_burst_packer
  import online_pkg::*;
#(
  parameter int no_of_digits = DEFAULT_NO_OF_DIGITS,
  parameter int radix_bits   = DEFAULT_RADIX_BITS,
  parameter int burst_index  = 8,
  parameter int addr_bits    = 10
) (
  input  logic                  variable_clk,
  input  logic                  rst,
  online_burst_packer_if.slave  bus
);
  localparam int         NB   = calc_nb(no_of_digits, radix_bits);
  localparam int         W    = NB * burst_index;
  localparam logic [3:0] LAST = 4'(burst_index - 1);
  localparam logic [3:0] FULL = 4'(burst_index);

  logic [W-1:0] r_pack;
  logic [3:0]   r_beat_cnt;
  pack_state_e  r_state;
  pack_state_e  w_state_next;

  logic         w_blocked;
  logic         w_din_ready;
  logic         w_accept;
  logic         w_load;
  logic [W-1:0] w_shifted;
  logic [W-1:0] w_pack_next;
  logic [W-1:0] w_word;
  logic [3:0]   w_cnt_next;
  logic [31:0]  w_shamt;

  if (burst_index == 1) begin : g_single
    assign w_shifted = bus.Dout;
  end else begin : g_multi
    assign w_shifted = {r_pack[W-NB-1:0], bus.Dout};
  end

  always_comb begin
    w_state_next = r_state;
    w_blocked    = (r_state == ST_EMIT) && !bus.mem_ready;
    w_din_ready  = !(w_blocked && ((r_beat_cnt == LAST) || bus.flush));
    w_accept     = bus.din_valid && w_din_ready;
    w_pack_next  = w_accept ? w_shifted : r_pack;
    w_cnt_next   = r_beat_cnt + {3'd0, w_accept};
    w_load       = !w_blocked &&
                   ((w_cnt_next == FULL) || (bus.flush && (w_cnt_next != 4'd0)));
    // Left-align the valid results; a complete burst needs no shift.
    w_shamt      = 32'(NB) * (32'(burst_index) - 32'(w_cnt_next));
    w_word       = w_pack_next << w_shamt;

    if (w_load || w_blocked) begin
      w_state_next = ST_EMIT;
    end else if (w_cnt_next == 4'd0) begin
      w_state_next = ST_IDLE;
    end else begin
      w_state_next = ST_FILL;
    end
  end

  always_ff @(posedge variable_clk) begin
    if (rst) begin
      r_pack     <= '0;
      r_beat_cnt <= '0;
      r_state    <= ST_IDLE;
    end else begin
      r_pack     <= w_pack_next;
      r_beat_cnt <= w_load ? 4'd0 : w_cnt_next;
      r_state    <= w_state_next;
    end
  end

  assign bus.din_ready = w_din_ready;
  assign bus.beat_cnt  = r_beat_cnt;

  burst_out_reg #(
    .W         (W),
    .ADDR_BITS (addr_bits)
  ) u_out (
    .clk     (variable_clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_word),
    .i_ready (bus.mem_ready),
    .o_we    (bus.mem_we),
    .o_data  (bus.mem_in),
    .o_addr  (bus.mem_addr)
  );
endmodule

// File: tb/tb_online_burst_packer.sv
// tb/tb_online_burst_packer.sv - scoreboard bench for online_burst_packer (default and burst_index=1/addr_bits=2 builds)
module tb_online_burst_packer;
  import online_pkg::*;

  localparam int NB = calc_nb(DEFAULT_NO_OF_DIGITS, DEFAULT_RADIX_BITS);
  localparam int WA = NB * 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  online_burst_packer_if #(.NB(NB), .BURST_INDEX(8), .ADDR_BITS(10)) bus_a();
  online_burst_packer_if #(.NB(NB), .BURST_INDEX(1), .ADDR_BITS(2))  bus_b();

  online_burst_packer #(
    .no_of_digits(8), .radix_bits(3), .burst_index(8), .addr_bits(10)
  ) dut_a (
    .variable_clk (clk),
    .rst          (rst),
    .bus          (bus_a)
  );

  online_burst_packer #(
    .no_of_digits(8), .radix_bits(3), .burst_index(1), .addr_bits(2)
  ) dut_b (
    .variable_clk (clk),
    .rst          (rst),
    .bus          (bus_b)
  );

  typedef struct packed {
    logic [WA-1:0] data;
    logic [9:0]    addr;
  } exp_a_t;

  typedef struct packed {
    logic [NB-1:0] data;
    logic [1:0]    addr;
  } exp_b_t;

  exp_a_t        sb_a[$];
  exp_b_t        sb_b[$];
  logic [NB-1:0] pend_a[$];
  int n_checks   = 0;
  int n_errors   = 0;
  int exp_addr_a = 0;
  int exp_addr_b = 0;
  logic stable;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word_a();
    exp_a_t e;
    e.data = '0;
    foreach (pend_a[i]) e.data[NB*(7-i) +: NB] = pend_a[i];
    e.addr = 10'(exp_addr_a);
    sb_a.push_back(e);
    exp_addr_a = (exp_addr_a + 1) % 1024;
    pend_a.delete();
  endtask

  task automatic send_a(input logic [NB-1:0] v, input logic fl);
    int   n   = 0;
    logic acc = 1'b0;
    bus_a.Dout      = v;
    bus_a.din_valid = 1'b1;
    bus_a.flush     = fl;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus_a.din_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus_a.din_valid = 1'b0;
    bus_a.flush     = 1'b0;
    check_eq("send_a_accepted", acc, 1'b1);
    if (acc) begin
      pend_a.push_back(v);
      if (pend_a.size() == 8 || fl) push_word_a();
    end
  endtask

  task automatic flush_a();
    bus_a.flush = 1'b1;
    tick(1);
    bus_a.flush = 1'b0;
    if (pend_a.size() != 0) push_word_a();
  endtask

  task automatic send_b(input logic [NB-1:0] v, input logic fl);
    int   n   = 0;
    logic acc = 1'b0;
    exp_b_t e;
    bus_b.Dout      = v;
    bus_b.din_valid = 1'b1;
    bus_b.flush     = fl;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus_b.din_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus_b.din_valid = 1'b0;
    bus_b.flush     = 1'b0;
    check_eq("send_b_accepted", acc, 1'b1);
    if (acc) begin
      e.data = v;
      e.addr = 2'(exp_addr_b);
      sb_b.push_back(e);
      exp_addr_b = (exp_addr_b + 1) % 4;
    end
  endtask

  task automatic reset_checks_a();
    check_eq("rst_mem_we",    bus_a.mem_we,    1'b0);
    check_eq("rst_mem_in",    bus_a.mem_in,    '0);
    check_eq("rst_mem_addr",  bus_a.mem_addr,  '0);
    check_eq("rst_beat_cnt",  bus_a.beat_cnt,  4'd0);
    check_eq("rst_din_ready", bus_a.din_ready, 1'b1);
  endtask

  // Writes complete at the next rising edge whenever we and ready are both high here.
  always @(negedge clk) begin
    exp_a_t ea;
    exp_b_t eb;
    if (!rst && bus_a.mem_we && bus_a.mem_ready) begin
      check_eq("wr_a_expected", sb_a.size() != 0, 1'b1);
      if (sb_a.size() != 0) begin
        ea = sb_a.pop_front();
        check_eq("wr_a_data", bus_a.mem_in,   ea.data);
        check_eq("wr_a_addr", bus_a.mem_addr, ea.addr);
      end
    end
    if (!rst && bus_b.mem_we && bus_b.mem_ready) begin
      check_eq("wr_b_expected", sb_b.size() != 0, 1'b1);
      if (sb_b.size() != 0) begin
        eb = sb_b.pop_front();
        check_eq("wr_b_data", bus_b.mem_in,   eb.data);
        check_eq("wr_b_addr", bus_b.mem_addr, eb.addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_a.Dout = '0; bus_a.din_valid = 1'b0; bus_a.flush = 1'b0; bus_a.mem_ready = 1'b1;
    bus_b.Dout = '0; bus_b.din_valid = 1'b0; bus_b.flush = 1'b0; bus_b.mem_ready = 1'b1;
    tick(3);
    reset_checks_a();
    check_eq("rst_b_mem_we",   bus_b.mem_we,   1'b0);
    check_eq("rst_b_mem_addr", bus_b.mem_addr, '0);
    rst = 1'b0;
    tick(1);

    // Full bursts, one-cycle latency to mem_we
    for (int i = 1; i <= 7; i++) send_a(NB'(i), 1'b0);
    check_eq("fill_beat_cnt", bus_a.beat_cnt, 4'd7);
    check_eq("fill_no_we",    bus_a.mem_we,   1'b0);
    send_a(NB'(8), 1'b0);
    check_eq("burst_we_latency", bus_a.mem_we,   1'b1);
    check_eq("burst_cnt_zero",   bus_a.beat_cnt, 4'd0);
    for (int i = 11; i <= 18; i++) send_a(NB'(i), 1'b0);
    tick(3);

    // Partial flush, then a flush with nothing pending
    send_a(NB'(5), 1'b0); send_a(NB'(6), 1'b0); send_a(NB'(7), 1'b0);
    flush_a();
    check_eq("flush_cnt_zero", bus_a.beat_cnt, 4'd0);
    check_eq("flush_we",       bus_a.mem_we,   1'b1);
    tick(3);
    flush_a();
    tick(2);
    check_eq("noop_flush_we", bus_a.mem_we, 1'b0);

    // Flush coinciding with a beat: partial, then full
    send_a(NB'(21), 1'b0); send_a(NB'(22), 1'b0); send_a(NB'(9), 1'b1);
    tick(2);
    for (int i = 31; i <= 37; i++) send_a(NB'(i), 1'b0);
    send_a(NB'(38), 1'b1);
    tick(3);

    // Back-pressure: hold the write, fill to 7, then release
    bus_a.mem_ready = 1'b0;
    for (int i = 41; i <= 48; i++) send_a(NB'(i), 1'b0);
    for (int i = 51; i <= 57; i++) send_a(NB'(i), 1'b0);
    check_eq("bp_cnt_seven",  bus_a.beat_cnt,  4'd7);
    check_eq("bp_din_ready",  bus_a.din_ready, 1'b0);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      stable &= bus_a.mem_we && (bus_a.mem_in == sb_a[0].data) && (bus_a.mem_addr == sb_a[0].addr);
    end
    check_eq("bp_hold_stable", stable, 1'b1);
    tick(0);
    fork
      send_a(NB'(58), 1'b0);
      begin tick(3); bus_a.mem_ready = 1'b1; end
    join
    tick(4);

    // Reset mid-burst
    for (int i = 61; i <= 64; i++) send_a(NB'(i), 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pend_a.delete();
    exp_addr_a = 0;
    reset_checks_a();

    // Reset while a write is held
    bus_a.mem_ready = 1'b0;
    for (int i = 71; i <= 78; i++) send_a(NB'(i), 1'b0);
    check_eq("held_we", bus_a.mem_we, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sb_a.delete();
    exp_addr_a = 0;
    reset_checks_a();
    bus_a.mem_ready = 1'b1;
    tick(5);
    check_eq("post_rst_no_we", bus_a.mem_we, 1'b0);
    for (int i = 81; i <= 88; i++) send_a(NB'(i), 1'b0);
    tick(3);

    // burst_index=1 with 2-bit address: wrap and flush behaviour
    for (int i = 0; i < 5; i++) send_b(NB'(100 + i), 1'b0);
    check_eq("b_cnt_zero", bus_b.beat_cnt, 4'd0);
    tick(2);
    bus_b.flush = 1'b1;
    tick(1);
    bus_b.flush = 1'b0;
    tick(1);
    check_eq("b_flush_no_we", bus_b.mem_we, 1'b0);
    send_b(NB'(200), 1'b1);
    tick(4);

    check_eq("sb_a_drained", sb_a.size(), 0);
    check_eq("sb_b_drained", sb_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
